ristretto_pipe_ctrl: RTL
========================

// Module: ristretto_pipe_ctrl
// PURPOSE
//  Pipeline control unit for the decode stage. Takes decode source/dest addresses, exe write-back and LSU completion info.
//  Drives decode forward enable/select, stall and issue. Tracks outstanding loads in a per-register scoreboard.
//  Sits between the decode stage, exe stage and LSU; sequences hand-over of each decoded instruction to exe.
// PARAMETERS
//  MaxLoads   2   max outstanding loads (1..7); decode of a further load stalls
//  CntWidth   16  width of the saturating stall-cycle counter
// PORTS
//  clk_i              in   1   clock
//  rstn_i             in   1   reset, asynchronous, active-low
//  pc_dec_valid_i     in   1   decode holds a valid instruction
//  pc_rs1_addr_i      in   5   decode rs1 address
//  pc_rs2_addr_i      in   5   decode rs2 address
//  pc_rs1_used_i      in   1   instruction reads rs1
//  pc_rs2_used_i      in   1   instruction reads rs2 (register operand, not immediate)
//  pc_dec_rd_addr_i   in   5   decode rd address
//  pc_dec_is_load_i   in   1   decoded instruction is a load
//  pc_exe_ready_i     in   1   exe accepts an instruction this cycle
//  pc_wb_valid_i      in   1   exe writes regfile this cycle
//  pc_wb_addr_i       in   5   exe write address
//  pc_lsu_done_i      in   1   load data written to regfile this cycle
//  pc_lsu_rd_addr_i   in   5   rd of completing load
//  pc_flush_i         in   1   branch/exception flush request
//  pc_issue_o         out  1   instruction handed to exe this cycle
//  pc_dec_stall_o     out  1   decode must hold its instruction
//  pc_forward_en_o    out  1   any forward active
//  pc_forward_src_o   out  2   [0]=replace op A, [1]=replace op B with wb data
//  pc_pending_o       out  32  scoreboard, bit n = load to xn outstanding (bit 0 always 0)
//  pc_state_o         out  2   FSM state: 00 RUN, 01 HAZ, 10 BUSY, 11 FLUSH
//  pc_stall_cnt_o     out  CntWidth  saturating count of cycles with pc_dec_stall_o=1
//  pc_err_o           out  1   sticky: lsu_done for a non-pending register, or a load issued with count==MaxLoads
// BEHAVIOUR
//  Reset (async, rstn_i=0): state RUN, scoreboard 0, load count 0, stall_cnt 0, err 0. All outputs 0 while dec_valid=0.
//  Forward (comb): src[0]=wb_valid & wb_addr!=0 & rs1_used & wb_addr==rs1. src[1] likewise for rs2. en=|src.
//  hazard (comb): (rs1_used & pending[rs1]) | (rs2_used & pending[rs2]) | (pending[rd] & rd!=0)  [WAW]
//                 | (is_load & count==MaxLoads). pending bit still counts in the lsu_done cycle (regfile written at that edge).
//  issue = dec_valid & ~flush_i & state!=FLUSH & ~hazard & exe_ready. stall = dec_valid & ~issue. Both comb.
//  Scoreboard at edge: set bit rd on issue & is_load & rd!=0; clear bit lsu_rd on lsu_done. Same bit set+clear: set wins.
//  Load count: +1 on load issue, -1 on lsu_done for a pending bit; both together -> unchanged; never wraps.
//  Load to x0 on issue: no scoreboard bit, no count increment.
//  FSM next state, priority order: flush_i -> FLUSH; state==FLUSH -> RUN; dec_valid&hazard -> HAZ;
//    dec_valid&~exe_ready -> BUSY; else RUN. FLUSH lasts exactly 1 cycle; issue blocked in it and in flush_i cycle.
//  Flush does not clear scoreboard or count; in-flight loads still complete.
//  stall_cnt +1 each cycle stall=1, saturates at all-ones. err set per PORTS, cleared only by reset.
//  Reset mid-operation: all state cleared immediately, no wait for clock.
// TESTING
//  Back-to-back ALU: wb_valid=1 wb_addr=5, rs1=5 used -> forward_src=01, issue=1, stall=0.
//  Load x7 issued; next instr rs2=7 -> stall=1, state HAZ, pending[7]=1; lsu_done x7 -> stall that cycle, issue next cycle.
//  MaxLoads=2: two loads x3,x4 outstanding, third load -> stall; lsu_done x3 same cycle -> still stall, issue next cycle.
//  exe_ready=0 for 3 cycles with dec_valid=1 -> state BUSY, stall_cnt=3; exe_ready=1 -> issue, state RUN.
//  flush_i pulse with load pending on x9 -> issue=0 for 2 cycles, state FLUSH then RUN, pending[9] stays 1.
//  lsu_done for x12 not pending -> err=1 sticky; assert rstn_i=0 mid-cycle -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ristretto_pipe_ctrl.sv
// Decode-stage pipeline control: forwarding select, hazard stall, issue and a per-register load scoreboard.
// Issue, stall and forward selects are combinational; the scoreboard, FSM, stall counter and error flag update at the clock edge.
module ristretto_pipe_ctrl #(
  parameter int MaxLoads = 2,
  parameter int CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                pc_dec_valid_i,
  input  logic [4:0]          pc_rs1_addr_i,
  input  logic [4:0]          pc_rs2_addr_i,
  input  logic                pc_rs1_used_i,
  input  logic                pc_rs2_used_i,
  input  logic [4:0]          pc_dec_rd_addr_i,
  input  logic                pc_dec_is_load_i,
  input  logic                pc_exe_ready_i,
  input  logic                pc_wb_valid_i,
  input  logic [4:0]          pc_wb_addr_i,
  input  logic                pc_lsu_done_i,
  input  logic [4:0]          pc_lsu_rd_addr_i,
  input  logic                pc_flush_i,
  output logic                pc_issue_o,
  output logic                pc_dec_stall_o,
  output logic                pc_forward_en_o,
  output logic [1:0]          pc_forward_src_o,
  output logic [31:0]         pc_pending_o,
  output logic [1:0]          pc_state_o,
  output logic [CntWidth-1:0] pc_stall_cnt_o,
  output logic                pc_err_o
);

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_HAZ   = 2'b01;
  localparam logic [1:0] ST_BUSY  = 2'b10;
  localparam logic [1:0] ST_FLUSH = 2'b11;

  localparam logic [2:0] MAX_CNT = 3'(MaxLoads);
  localparam logic [CntWidth-1:0] CNT_ONE = {{(CntWidth-1){1'b0}}, 1'b1};

  logic [31:0]         pending;
  logic [31:0]         pending_nxt;
  logic [2:0]          load_cnt;
  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [CntWidth-1:0] stall_cnt;
  logic                err;

  logic       fwd_a;
  logic       fwd_b;
  logic       cnt_full;
  logic       hazard;
  logic       issue;
  logic       stall;
  logic       load_set;
  logic       done_hit;
  logic       err_set;

  // Forwarding is only meaningful for a live decode slot; x0 is never forwarded.
  assign fwd_a = pc_dec_valid_i && pc_wb_valid_i && (pc_wb_addr_i != 5'd0) &&
                 pc_rs1_used_i && (pc_wb_addr_i == pc_rs1_addr_i);
  assign fwd_b = pc_dec_valid_i && pc_wb_valid_i && (pc_wb_addr_i != 5'd0) &&
                 pc_rs2_used_i && (pc_wb_addr_i == pc_rs2_addr_i);

  assign cnt_full = (load_cnt == MAX_CNT);

  // A pending bit still blocks in its lsu_done cycle since the regfile is written at that edge.
  assign hazard = (pc_rs1_used_i && pending[pc_rs1_addr_i]) ||
                  (pc_rs2_used_i && pending[pc_rs2_addr_i]) ||
                  ((pc_dec_rd_addr_i != 5'd0) && pending[pc_dec_rd_addr_i]) ||
                  (pc_dec_is_load_i && cnt_full);

  assign issue = pc_dec_valid_i && !pc_flush_i && (state != ST_FLUSH) &&
                 !hazard && pc_exe_ready_i;
  assign stall = pc_dec_valid_i && !issue;

  assign load_set = issue && pc_dec_is_load_i && (pc_dec_rd_addr_i != 5'd0);
  assign done_hit = pc_lsu_done_i && pending[pc_lsu_rd_addr_i];
  assign err_set  = (pc_lsu_done_i && !pending[pc_lsu_rd_addr_i]) ||
                    (issue && pc_dec_is_load_i && cnt_full);

  // Clear first so that a simultaneous set on the same bit wins.
  always_comb begin
    pending_nxt = pending;
    if (pc_lsu_done_i) begin
      pending_nxt[pc_lsu_rd_addr_i] = 1'b0;
    end
    if (load_set) begin
      pending_nxt[pc_dec_rd_addr_i] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_comb begin
    state_nxt = ST_RUN;
    if (pc_flush_i) begin
      state_nxt = ST_FLUSH;
    end else if (state == ST_FLUSH) begin
      state_nxt = ST_RUN;
    end else if (pc_dec_valid_i && hazard) begin
      state_nxt = ST_HAZ;
    end else if (pc_dec_valid_i && !pc_exe_ready_i) begin
      state_nxt = ST_BUSY;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pending   <= '0;
      load_cnt  <= '0;
      state     <= ST_RUN;
      stall_cnt <= '0;
      err       <= 1'b0;
    end else begin
      pending <= pending_nxt;
      state   <= state_nxt;
      case ({load_set, done_hit})
        2'b10: if (load_cnt != 3'd7) load_cnt <= load_cnt + 3'd1;
        2'b01: if (load_cnt != 3'd0) load_cnt <= load_cnt - 3'd1;
        default: load_cnt <= load_cnt;
      endcase
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

  assign pc_issue_o       = issue;
  assign pc_dec_stall_o   = stall;
  assign pc_forward_src_o = {fwd_b, fwd_a};
  assign pc_forward_en_o  = fwd_a || fwd_b;
  assign pc_pending_o     = pending;
  assign pc_state_o       = state;
  assign pc_stall_cnt_o   = stall_cnt;
  assign pc_err_o         = err;

endmodule
